// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register bank write port between ALU and load writeback, MEM-first with ALU anti-starvation.
// Optional RF_ARB_X0_DROP_EN suppresses regWrite for granted writes to register 0.
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              grant_src
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0]        wait_cnt;
  logic              force_alu, drop;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  always_comb begin
    force_alu = wait_cnt == MW;
    alu_ready = !rst && !stall && alu_valid && (!mem_valid || force_alu);
    mem_ready = !rst && !stall && mem_valid && !(alu_valid && force_alu);
    sel_reg   = mem_ready ? mem_reg : alu_reg;
    sel_data  = mem_ready ? mem_data : alu_data;
`ifdef RF_ARB_X0_DROP_EN
    drop = sel_reg == '0;
`else
    drop = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      grant_src <= 1'b0;
    end else begin
      wait_cnt <= alu_ready ? 4'd0 : (alu_valid && !force_alu) ? wait_cnt + 4'd1 : wait_cnt;
      regWrite <= (alu_ready || mem_ready) && !drop;
      if (alu_ready || mem_ready) begin
        writeReg  <= sel_reg;
        writeData <= sel_data;
        grant_src <= mem_ready;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed-vector bench for regfile_write_arbiter with a bench-side register bank.
module tb_regfile_write_arbiter;
  logic        clk = 0, rst = 1, stall = 0;
  logic        alu_valid = 0, mem_valid = 0;
  logic [4:0]  alu_reg = 0, mem_reg = 0;
  logic [63:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, mem_ready, regWrite, grant_src;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic [63:0] bank [32];
  int n_checks = 0, n_fail = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .grant_src(grant_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (regWrite) bank[writeReg] <= writeData;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = '0;
    alu_valid = 1; mem_valid = 1;
    step(); step();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_regWrite", regWrite, 0);
    check("rst_writeReg", writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_grant_src", grant_src, 0);
    check("rst_wait_cnt", dut.wait_cnt, 0);
    alu_valid = 0; mem_valid = 0; rst = 0;
    step();
    check("idle_regWrite", regWrite, 0);

    // single ALU write
    alu_valid = 1; alu_reg = 5; alu_data = 64'hDEAD_BEEF;
    #1;
    check("t1_alu_ready", alu_ready, 1);
    check("t1_mem_ready", mem_ready, 0);
    step();
    alu_valid = 0;
    check("t1_regWrite", regWrite, 1);
    check("t1_writeReg", writeReg, 5);
    check("t1_writeData", writeData, 64'hDEAD_BEEF);
    check("t1_grant_src", grant_src, 0);
    step();
    check("t1_idle_regWrite", regWrite, 0);
    check("t1_hold_writeReg", writeReg, 5);

    // contention: MEM,MEM,MEM,ALU repeating
    alu_valid = 1; mem_valid = 1; alu_reg = 10; alu_data = 64'hA0; mem_reg = 20; mem_data = 64'hB0;
    for (int i = 0; i < 8; i++) begin
      logic exp_alu;
      exp_alu = (i % 4) == 3;
      #1;
      check($sformatf("t2_alu_ready_%0d", i), alu_ready, exp_alu);
      check($sformatf("t2_mem_ready_%0d", i), mem_ready, !exp_alu);
      step();
      check($sformatf("t2_regWrite_%0d", i), regWrite, 1);
      check($sformatf("t2_src_%0d", i), grant_src, !exp_alu);
      check($sformatf("t2_reg_%0d", i), writeReg, exp_alu ? alu_reg : mem_reg);
      if (exp_alu) begin
        check($sformatf("t2_wait_clear_%0d", i), dut.wait_cnt, 0);
        alu_reg = alu_reg + 1; alu_data = alu_data + 1;
      end else begin
        mem_reg = mem_reg + 1; mem_data = mem_data + 1;
      end
    end

    // 4-cycle stall saturates wait_cnt, so ALU wins on release
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_alu_ready_%0d", i), alu_ready, 0);
      check($sformatf("t3_mem_ready_%0d", i), mem_ready, 0);
      step();
      check($sformatf("t3_regWrite_%0d", i), regWrite, 0);
    end
    check("t3_wait_sat", dut.wait_cnt, 3);
    stall = 0;
    #1;
    check("t3_rel_alu_ready", alu_ready, 1);
    step();
    check("t3_rel_src", grant_src, 0);
    check("t3_rel_reg", writeReg, alu_reg);
    alu_reg = 15;
    // 1-cycle stall from wait_cnt 0: MEM wins on release
    stall = 1;
    step();
    check("t3b_regWrite", regWrite, 0);
    stall = 0;
    #1;
    check("t3b_mem_ready", mem_ready, 1);
    step();
    check("t3b_src", grant_src, 1);
    mem_valid = 0;
    #1;
    check("t3b_alu_alone", alu_ready, 1);
    step();
    check("t3b_wait_clear", dut.wait_cnt, 0);

    // same destination: MEM first, then ALU overwrites
    alu_valid = 1; mem_valid = 1; alu_reg = 7; mem_reg = 7; alu_data = 1; mem_data = 2;
    #1;
    check("t4_mem_first", mem_ready, 1);
    step();
    mem_valid = 0;
    check("t4_w1_src", grant_src, 1);
    check("t4_w1_data", writeData, 2);
    #1;
    check("t4_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    check("t4_w2_src", grant_src, 0);
    check("t4_w2_data", writeData, 1);
    step();
    check("t4_bank_r7", bank[7], 1);

    // write to x0
    mem_valid = 1; mem_reg = 0; mem_data = 64'h55;
    #1;
    check("t5_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
`ifdef RF_ARB_X0_DROP_EN
    check("t5_regWrite_dropped", regWrite, 0);
`else
    check("t5_regWrite", regWrite, 1);
    check("t5_writeReg", writeReg, 0);
    check("t5_writeData", writeData, 64'h55);
`endif

    // reset right after a grant, request still valid
    mem_valid = 1; mem_reg = 9; mem_data = 64'h99;
    #1;
    check("t6_mem_ready", mem_ready, 1);
    step();
    check("t6_regWrite", regWrite, 1);
    check("t6_src", grant_src, 1);
    rst = 1;
    #1;
    check("t6_rst_ready", mem_ready, 0);
    step();
    check("t6_rst_regWrite", regWrite, 0);
    check("t6_rst_writeReg", writeReg, 0);
    check("t6_rst_writeData", writeData, 0);
    check("t6_rst_src", grant_src, 0);
    rst = 0;
    #1;
    check("t6_rel_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    check("t6_rel_regWrite", regWrite, 1);
    check("t6_rel_writeReg", writeReg, 9);
    check("t6_rel_writeData", writeData, 64'h99);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
